engine_dispatcher: RTL



---
 rtl/engine_dispatcher.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/engine_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : engine_dispatcher
//  Description : Routes the host input stream to one of NUM_ENGINES
//                Smith-Waterman engines. A packet is one header word followed
//                by N payload words, where N = header[LEN_WIDTH-1:0]. The
//                whole packet goes to one engine. That engine is picked
//                round-robin among the engines that are ready when the header
//                is accepted. Words pass through a one-deep registered output
//                slot.
//  Optional    : ENGINE_DISPATCHER_STATS_EN adds the pkt_count_out port. It is
//                a saturating 32-bit count of accepted headers.
//  Ports       :
//    clk            engine clock
//    rst_n          asynchronous active-low reset
//    si_valid_in    upstream word valid
//    si_data_in     upstream word
//    si_rdy_out     upstream ready (combinational)
//    eng_valid_out  one-hot valid to the selected engine
//    eng_data_out   word broadcast to all engines
//    eng_rdy_in     per-engine ready
//    busy_out       packet in progress or output slot occupied
//    pkt_count_out  accepted header count (STATS_EN builds only)
//  Revision    : 1.0 - initial release
// ============================================================================
module engine_dispatcher #(
  parameter int NUM_ENGINES = 4,
  parameter int DATA_WIDTH  = 128,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   si_valid_in,
  input  logic [DATA_WIDTH-1:0]  si_data_in,
  output logic                   si_rdy_out,
  output logic [NUM_ENGINES-1:0] eng_valid_out,
  output logic [DATA_WIDTH-1:0]  eng_data_out,
  input  logic [NUM_ENGINES-1:0] eng_rdy_in,
  output logic                   busy_out
`ifdef ENGINE_DISPATCHER_STATS_EN
  ,
  output logic [31:0]            pkt_count_out
`endif
);

  localparam int               SEL_W       = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [SEL_W:0]   C_NUM_ENG   = (SEL_W+1)'(NUM_ENGINES);
  localparam logic [SEL_W-1:0] C_LAST_ENG  = SEL_W'(NUM_ENGINES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FWD  = 1'b1
  } state_t;

  state_t                 state_q;
  logic [LEN_WIDTH-1:0]   cnt_q;
  logic                   out_valid_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic [SEL_W-1:0]       out_sel_q;
  logic [SEL_W-1:0]       last_grant_q;

  logic                   w_slot_free;
  logic                   w_accept;
  logic                   w_transfer;
  logic [SEL_W-1:0]       w_grant;
  logic                   w_grant_found;
  logic [SEL_W:0]         w_cand;
  logic [LEN_WIDTH-1:0]   w_hdr_len;

  // The slot can take a new word when it is empty or when it is draining this
  // cycle. Only the engine that owns the slot can make it drain.
  assign w_slot_free = !out_valid_q || eng_rdy_in[out_sel_q];
  assign w_transfer  = out_valid_q && eng_rdy_in[out_sel_q];
  assign w_hdr_len   = si_data_in[LEN_WIDTH-1:0];

  // While a header is expected, at least one engine must be ready for a grant.
  // During a payload, only the slot owner matters.
  always_comb begin
    si_rdy_out = 1'b0;
    if (rst_n) begin
      if (state_q == ST_IDLE) begin
        si_rdy_out = w_slot_free && (|eng_rdy_in);
      end else begin
        si_rdy_out = w_slot_free;
      end
    end
  end

  assign w_accept = si_valid_in && si_rdy_out;

  // Round-robin search that starts just after the previous grant.
  // last_grant + 1 + i is below 2*NUM_ENGINES, so one subtraction is enough to wrap it.
  always_comb begin
    w_grant       = '0;
    w_grant_found = 1'b0;
    w_cand        = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      w_cand = {1'b0, last_grant_q} + (SEL_W+1)'(i + 1);
      if (w_cand >= C_NUM_ENG) begin
        w_cand = w_cand - C_NUM_ENG;
      end
      if (!w_grant_found && eng_rdy_in[w_cand[SEL_W-1:0]]) begin
        w_grant       = w_cand[SEL_W-1:0];
        w_grant_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      last_grant_q <= C_LAST_ENG;
    end else begin
      if (w_accept) begin
        // An accept always refills the slot. If the slot drained in the same
        // cycle, the engines see no bubble.
        out_valid_q <= 1'b1;
        out_data_q  <= si_data_in;
        if (state_q == ST_IDLE) begin
          out_sel_q    <= w_grant;
          last_grant_q <= w_grant;
          cnt_q        <= w_hdr_len;
          state_q      <= (w_hdr_len == '0) ? ST_IDLE : ST_FWD;
        end else begin
          cnt_q <= cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_q <= ST_IDLE;
          end
        end
      end else if (w_transfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    eng_valid_out = '0;
    if (out_valid_q) begin
      eng_valid_out[out_sel_q] = 1'b1;
    end
  end

  assign eng_data_out = out_data_q;
  assign busy_out     = (state_q == ST_FWD) || out_valid_q;

`ifdef ENGINE_DISPATCHER_STATS_EN
  logic [31:0] pkt_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_q <= '0;
    end else if (w_accept && (state_q == ST_IDLE) && (pkt_count_q != '1)) begin
      pkt_count_q <= pkt_count_q + 32'd1;
    end
  end

  assign pkt_count_out = pkt_count_q;
`else
  // Packet statistics are not built; there is no counter state.
`endif

endmodule
`default_nettype wire
